hoplite_node_interface: RTL

Network-side endpoint for one Fox/Hoplite processing node. It turns the node's per-field memory-mapped write strobes into a single packed packet and injects it into the Hoplite router with a valid/ready handshake. In the other direction it buffers packets ejected by the router in a small FIFO and presents them back to the node as read-only fields, popped by `message_in_read`. It sits between each `system` instance and its router port.

---
 rtl/hoplite_if_pkg.sv | 54 +++++
 rtl/hoplite_rx_fifo.sv | 54 +++++
 rtl/hoplite_node_interface.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/hoplite_if_pkg.sv
// ============================================================================
// hoplite_if_pkg: shared packet layout, TX state encoding and pack helpers.
// Revision: 1.0
// ============================================================================
`default_nettype none

package hoplite_if_pkg;

  localparam int COORD_W     = 1;
  localparam int MCAST_W     = 1;
  localparam int MTYPE_W     = 1;
  localparam int MCOORD_W    = 8;
  localparam int MELEM_W     = 32;
  localparam int PACKET_BITS = 2*COORD_W + MCAST_W + 2 + MTYPE_W + 2*MCOORD_W + MELEM_W;

  // Bit offsets (LSB) of each field; x_coord sits at the MSB end.
  localparam int ELEM_LSB   = 0;
  localparam int MY_LSB     = ELEM_LSB + MELEM_W;
  localparam int MX_LSB     = MY_LSB + MCOORD_W;
  localparam int MTYPE_LSB  = MX_LSB + MCOORD_W;
  localparam int RESULT_LSB = MTYPE_LSB + MTYPE_W;
  localparam int DONE_LSB   = RESULT_LSB + 1;
  localparam int MCAST_LSB  = DONE_LSB + 1;
  localparam int Y_LSB      = MCAST_LSB + MCAST_W;
  localparam int X_LSB      = Y_LSB + COORD_W;

  typedef enum logic [0:0] {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_e;

  typedef struct packed {
    logic [COORD_W-1:0]  x_coord;
    logic [COORD_W-1:0]  y_coord;
    logic [MCAST_W-1:0]  multicast_group;
    logic                done_flag;
    logic                result_flag;
    logic [MTYPE_W-1:0]  matrix_type;
    logic [MCOORD_W-1:0] matrix_x_coord;
    logic [MCOORD_W-1:0] matrix_y_coord;
    logic [MELEM_W-1:0]  matrix_element;
  } packet_t;

  function automatic logic [PACKET_BITS-1:0] pack_packet(input packet_t p);
    return p;
  endfunction

  function automatic packet_t unpack_packet(input logic [PACKET_BITS-1:0] b);
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hoplite_rx_fifo.sv
// ============================================================================
// hoplite_rx_fifo: RX packet FIFO with extra-bit wrap pointers for full/empty.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hoplite_rx_fifo #(
  parameter  int RX_DEPTH = 4,
  parameter  int WIDTH    = 8,
  localparam int AW       = $clog2(RX_DEPTH),
  localparam int CW       = AW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [RX_DEPTH];
  logic [CW-1:0]    wr_q;
  logic [CW-1:0]    rd_q;
  logic             w_push;
  logic             w_pop;

  assign count_o = wr_q - rd_q;
  assign full_o  = (count_o == CW'(RX_DEPTH));
  assign empty_o = (wr_q == rd_q);
  assign w_pop   = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a write to a full FIFO is legal then.
  assign w_push  = push_i && (!full_o || w_pop);
  assign data_o  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (w_push) wr_q <= wr_q + CW'(1);
      if (w_pop)  rd_q <= rd_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

`default_nettype wire

// File: rtl/hoplite_node_interface.sv
// ============================================================================
// hoplite_node_interface: node field registers -> Hoplite TX, RX FIFO -> node.
// Optional destination filter: HOPLITE_IF_RX_FILTER_EN.  Revision: 1.0
// ============================================================================
`default_nettype none

module hoplite_node_interface
  import hoplite_if_pkg::*;
#(
  parameter  int X_COORD              = 0,
  parameter  int Y_COORD              = 0,
  parameter  int COORD_BITS           = COORD_W,
  parameter  int MULTICAST_GROUP_BITS = MCAST_W,
  parameter  int MATRIX_TYPE_BITS     = MTYPE_W,
  parameter  int MATRIX_COORD_BITS    = MCOORD_W,
  parameter  int MATRIX_ELEMENT_BITS  = MELEM_W,
  parameter  int RX_DEPTH             = 4,
  localparam int PKT_W = 2*COORD_BITS + MULTICAST_GROUP_BITS + 2 + MATRIX_TYPE_BITS
                       + 2*MATRIX_COORD_BITS + MATRIX_ELEMENT_BITS,
  localparam int HW    = PKT_W - 2*COORD_BITS,
  localparam int CW    = $clog2(RX_DEPTH) + 1
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [COORD_BITS-1:0]           x_coord_in,
  input  logic                            x_coord_in_valid,
  input  logic [COORD_BITS-1:0]           y_coord_in,
  input  logic                            y_coord_in_valid,
  input  logic [MULTICAST_GROUP_BITS-1:0] multicast_group_in,
  input  logic                            multicast_group_in_valid,
  input  logic                            done_flag_in,
  input  logic                            done_flag_in_valid,
  input  logic                            result_flag_in,
  input  logic                            result_flag_in_valid,
  input  logic [MATRIX_TYPE_BITS-1:0]     matrix_type_in,
  input  logic                            matrix_type_in_valid,
  input  logic [MATRIX_COORD_BITS-1:0]    matrix_x_coord_in,
  input  logic                            matrix_x_coord_in_valid,
  input  logic [MATRIX_COORD_BITS-1:0]    matrix_y_coord_in,
  input  logic                            matrix_y_coord_in_valid,
  input  logic [MATRIX_ELEMENT_BITS-1:0]  matrix_element_in,
  input  logic                            matrix_element_in_valid,
  input  logic                            packet_complete_in,
  output logic                            message_out_ready,
  output logic [MULTICAST_GROUP_BITS-1:0] multicast_group_out,
  output logic                            done_flag_out,
  output logic                            result_flag_out,
  output logic [MATRIX_TYPE_BITS-1:0]     matrix_type_out,
  output logic [MATRIX_COORD_BITS-1:0]    matrix_x_coord_out,
  output logic [MATRIX_COORD_BITS-1:0]    matrix_y_coord_out,
  output logic [MATRIX_ELEMENT_BITS-1:0]  matrix_element_out,
  output logic                            message_in_available,
  output logic                            message_in_valid,
  input  logic                            message_in_read,
  output logic [PKT_W-1:0]                packet_out,
  output logic                            packet_out_valid,
  input  logic                            packet_out_ready,
  input  logic [PKT_W-1:0]                packet_in,
  input  logic                            packet_in_valid,
  output logic                            tx_overrun,
  output logic                            rx_overflow,
  output logic                            rx_misroute
);

  logic [COORD_BITS-1:0]           x_q, x_d, y_q, y_d;
  logic [MULTICAST_GROUP_BITS-1:0] mg_q, mg_d;
  logic                            done_q, done_d, res_q, res_d;
  logic [MATRIX_TYPE_BITS-1:0]     mt_q, mt_d;
  logic [MATRIX_COORD_BITS-1:0]    mx_q, mx_d, my_q, my_d;
  logic [MATRIX_ELEMENT_BITS-1:0]  me_q, me_d;

  tx_state_e    state_q, state_d;
  logic [PKT_W-1:0] pkt_q, pkt_d;
  logic         overrun_q, overrun_d;

  logic [HW-1:0] head_q, head_d;
  logic          head_valid_q, head_valid_d;
  logic          head_pend_q, head_pend_d;
  logic          avail_q, avail_d;
  logic          overflow_q, overflow_d;

  logic          w_accept, w_rd_ok, w_fifo_push, w_fifo_pop;
  logic          w_fifo_full, w_fifo_empty;
  logic [HW-1:0] w_fifo_dout;
  logic [CW-1:0] w_fifo_cnt;

  // The _d values double as the capture bypass for strobes coincident with complete.
  assign x_d    = x_coord_in_valid        ? x_coord_in        : x_q;
  assign y_d    = y_coord_in_valid        ? y_coord_in        : y_q;
  assign mg_d   = multicast_group_in_valid ? multicast_group_in : mg_q;
  assign done_d = done_flag_in_valid      ? done_flag_in      : done_q;
  assign res_d  = result_flag_in_valid    ? result_flag_in    : res_q;
  assign mt_d   = matrix_type_in_valid    ? matrix_type_in    : mt_q;
  assign mx_d   = matrix_x_coord_in_valid ? matrix_x_coord_in : mx_q;
  assign my_d   = matrix_y_coord_in_valid ? matrix_y_coord_in : my_q;
  assign me_d   = matrix_element_in_valid ? matrix_element_in : me_q;

  always_comb begin
    state_d   = state_q;
    pkt_d     = pkt_q;
    overrun_d = overrun_q;
    case (state_q)
      TX_IDLE: begin
        if (packet_complete_in) begin
          state_d = TX_SEND;
          pkt_d   = {x_d, y_d, mg_d, done_d, res_d, mt_d, mx_d, my_d, me_d};
        end
      end
      TX_SEND: begin
        if (packet_out_ready)   state_d   = TX_IDLE;
        if (packet_complete_in) overrun_d = 1'b1;
      end
      default: state_d = TX_IDLE;
    endcase
  end

`ifdef HOPLITE_IF_RX_FILTER_EN
  logic w_misroute, misroute_q;
  assign w_accept = (packet_in[HW-1 -: MULTICAST_GROUP_BITS] != '0)
                 || ((packet_in[PKT_W-1 -: COORD_BITS] == COORD_BITS'(X_COORD))
                  && (packet_in[PKT_W-COORD_BITS-1 -: COORD_BITS] == COORD_BITS'(Y_COORD)));
  assign w_misroute = packet_in_valid && !w_accept;
  always_ff @(posedge clk) begin
    if (!reset_n) misroute_q <= 1'b0;
    else          misroute_q <= misroute_q | w_misroute;
  end
  assign rx_misroute = misroute_q;
`else
  logic unused_cfg;
  assign unused_cfg  = ^{packet_in[PKT_W-1 -: 2*COORD_BITS], X_COORD, Y_COORD};
  assign w_accept    = 1'b1;
  assign rx_misroute = 1'b0;
`endif

  // A pop reloads the head a cycle early (pending) so a full FIFO can accept a write.
  assign w_rd_ok     = message_in_read && head_valid_q;
  assign w_fifo_pop  = !w_fifo_empty && (w_rd_ok || (!head_valid_q && !head_pend_q));
  assign w_fifo_push = packet_in_valid && w_accept && (!w_fifo_full || w_fifo_pop);

  always_comb begin
    head_valid_d = head_valid_q;
    head_pend_d  = 1'b0;
    head_d       = w_fifo_pop ? w_fifo_dout : head_q;
    if (w_rd_ok) begin
      head_valid_d = 1'b0;
      head_pend_d  = w_fifo_pop;
    end else if (head_pend_q || w_fifo_pop) begin
      head_valid_d = 1'b1;
    end
    avail_d    = head_valid_d || head_pend_d || w_fifo_push || (w_fifo_cnt > CW'(w_fifo_pop));
    overflow_d = overflow_q | (packet_in_valid && w_accept && w_fifo_full && !w_fifo_pop);
  end

  hoplite_rx_fifo #(
    .RX_DEPTH (RX_DEPTH),
    .WIDTH    (HW)
  ) u_rx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (w_fifo_push),
    .pop_i   (w_fifo_pop),
    .data_i  (packet_in[HW-1:0]),
    .data_o  (w_fifo_dout),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty),
    .count_o (w_fifo_cnt)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      {x_q, y_q, mg_q, done_q, res_q, mt_q, mx_q, my_q, me_q} <= '0;
      state_q      <= TX_IDLE;
      pkt_q        <= '0;
      overrun_q    <= 1'b0;
      head_q       <= '0;
      head_valid_q <= 1'b0;
      head_pend_q  <= 1'b0;
      avail_q      <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      {x_q, y_q, mg_q, done_q, res_q, mt_q, mx_q, my_q, me_q} <=
        {x_d, y_d, mg_d, done_d, res_d, mt_d, mx_d, my_d, me_d};
      state_q      <= state_d;
      pkt_q        <= pkt_d;
      overrun_q    <= overrun_d;
      head_q       <= head_d;
      head_valid_q <= head_valid_d;
      head_pend_q  <= head_pend_d;
      avail_q      <= avail_d;
      overflow_q   <= overflow_d;
    end
  end

  assign message_out_ready    = (state_q == TX_IDLE);
  assign packet_out_valid     = (state_q == TX_SEND);
  assign packet_out           = pkt_q;
  assign tx_overrun           = overrun_q;
  assign rx_overflow          = overflow_q;
  assign message_in_valid     = head_valid_q;
  assign message_in_available = avail_q;
  assign {multicast_group_out, done_flag_out, result_flag_out, matrix_type_out,
          matrix_x_coord_out, matrix_y_coord_out, matrix_element_out} = head_q;

endmodule

`default_nettype wire
